// File: rtl/uart_tx_fifo.sv
// CPU-side UART transmitter: MMIO pushes fill a byte FIFO that an 8N1 serializer drains.
// All state is synchronous to iCpuClock with a synchronous active-high reset.
module uart_tx_fifo #(
    parameter int CLK_FREQ_HZ     = 23_000_000,
    parameter int BAUD_RATE       = 128_000,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                     iCpuClock,
    input  logic                     iCpuReset,
    input  logic                     iDoUartWrite,
    input  logic [7:0]               iUartDataToWrite,
    input  logic                     iClearOverflow,
    output logic                     oUartFull,
    output logic                     oUartIdle,
    output logic [FIFO_DEPTH_LOG2:0] oFifoCount,
    output logic                     oOverflow,
    output logic                     oUartTx
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int DEPTH        = 1 << FIFO_DEPTH_LOG2;
    localparam logic [BAUD_W-1:0]          BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_DEPTH_LOG2:0]   COUNT_FULL = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t                     state_q, state_d;
    logic [BAUD_W-1:0]          baud_q, baud_d;
    logic [2:0]                 bit_idx_q, bit_idx_d;
    logic [7:0]                 shift_q, shift_d;
    logic                       tx_q, tx_d;
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_DEPTH_LOG2:0]   count_q, count_d;
    logic                       ovf_q, ovf_d;
    logic [7:0]                 fifo_mem [DEPTH];

    logic full, empty, push, pop, baud_done;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop       = 1'b0;

        full      = (count_q == COUNT_FULL);
        empty     = (count_q == '0);
        push      = iDoUartWrite && !full;
        baud_done = (baud_q == BAUD_LAST);

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_mem[rd_ptr_q];
                    state_d = S_START;
                    tx_d    = 1'b0;
                    baud_d  = '0;
                end
            end
            S_START: begin
                if (baud_done) begin
                    state_d   = S_DATA;
                    baud_d    = '0;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_done) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when more bytes are waiting.
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_mem[rd_ptr_q];
                        state_d = S_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A dropped push outranks a clear arriving on the same edge.
        if (iDoUartWrite && full)  ovf_d = 1'b1;
        else if (iClearOverflow)   ovf_d = 1'b0;
        else                       ovf_d = ovf_q;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge iCpuClock) begin
        if (iCpuReset) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
        end
    end

    // NOTE: FIFO storage is not reset; the pointers and count alone decide which entries are valid.
    always_ff @(posedge iCpuClock) begin
        if (push) fifo_mem[wr_ptr_q] <= iUartDataToWrite;
    end

    assign oUartTx    = tx_q;
    assign oUartFull  = full;
    assign oUartIdle  = empty && (state_q == S_IDLE);
    assign oFifoCount = count_q;
    assign oOverflow  = ovf_q;

endmodule
